// File: rtl/fetch_queue_ctrl.sv
// Two-requester round-robin front end for the dual-push instruction queue:
// shares the push slots, tracks exact occupancy, and drives a valid/ready consumer.
module fetch_queue_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CAPACITY   = (1 << ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [1:0]            a_count,
  input  logic [DATA_WIDTH-1:0] a_data0,
  input  logic [DATA_WIDTH-1:0] a_data1,
  output logic [1:0]            a_grant,
  input  logic [1:0]            b_count,
  input  logic [DATA_WIDTH-1:0] b_data0,
  input  logic [DATA_WIDTH-1:0] b_data1,
  output logic [1:0]            b_grant,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  q_reset,
  output logic                  q_push0,
  output logic [DATA_WIDTH-1:0] q_data0,
  output logic                  q_push1,
  output logic [DATA_WIDTH-1:0] q_data1,
  output logic                  q_pop,
  input  logic [DATA_WIDTH-1:0] q_data_out,
  input  logic                  q_empty,
  input  logic                  q_full
);

  localparam int            OW  = ADDR_WIDTH + 1;
  localparam logic [OW-1:0] CAP = OW'(CAPACITY);
  localparam logic [OW-1:0] TWO = OW'(2);

  function automatic logic [1:0] sat_count(input logic [1:0] c);
    return (c == 2'd3) ? 2'd2 : c;
  endfunction

  function automatic logic [1:0] min2(input logic [1:0] x, input logic [1:0] y);
    return (x < y) ? x : y;
  endfunction

  logic [OW-1:0] occ_q, occ_d;
  logic          prio_q, prio_d;
  logic          out_valid_q, out_valid_d;

  logic          kill;
  logic          pop;
  logic [OW-1:0] free;
  logic [1:0]    allowed;
  logic [1:0]    a_req, b_req, win_req, grant;
  logic          sel_b;

  always_comb begin
    kill  = reset | flush;
    pop   = (occ_q != '0) && (!out_valid_q || out_ready) && !kill;
    free  = CAP - occ_q;
    // A popping cycle gives up the second slot so q_push1 never coincides with q_pop.
    if (kill) begin
      allowed = 2'd0;
    end else if (free >= TWO) begin
      allowed = pop ? 2'd1 : 2'd2;
    end else begin
      allowed = (free == '0) ? 2'd0 : 2'd1;
    end
    a_req   = sat_count(a_count);
    b_req   = sat_count(b_count);
    sel_b   = (a_req != 2'd0 && b_req != 2'd0) ? prio_q : (b_req != 2'd0);
    win_req = sel_b ? b_req : a_req;
    grant   = min2(win_req, allowed);
  end

  assign a_grant   = sel_b ? 2'd0 : grant;
  assign b_grant   = sel_b ? grant : 2'd0;
  assign q_push0   = (grant != 2'd0);
  assign q_push1   = (grant == 2'd2);
  assign q_data0   = sel_b ? b_data0 : a_data0;
  assign q_data1   = sel_b ? b_data1 : a_data1;
  assign q_pop     = pop;
  assign q_reset   = kill;
  assign out_valid = out_valid_q;
  assign out_data  = q_data_out;
  assign level     = occ_q;

  always_comb begin
    occ_d       = occ_q + OW'(grant) - OW'(pop);
    prio_d      = (grant != 2'd0) ? ~sel_b : prio_q;
    out_valid_d = out_valid_q;
    if (pop) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (kill) begin
      occ_d       = '0;
      prio_d      = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q       <= '0;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The queue's own status flags must track the occupancy kept here.
  a_no_pop_push1: assert property (@(posedge clk) disable iff (reset) !(q_push1 && q_pop));
  a_occ_bound:    assert property (@(posedge clk) disable iff (reset) occ_q <= CAP);
  a_empty_match:  assert property (@(posedge clk) disable iff (reset) q_empty == (occ_q == '0));
  a_full_match:   assert property (@(posedge clk) disable iff (reset) q_full == (occ_q == CAP));
  a_one_winner:   assert property (@(posedge clk) disable iff (reset)
                                   !(a_grant != 2'd0 && b_grant != 2'd0));

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Scoreboard bench for fetch_queue_ctrl with a behavioural model of the attached queue.
module tb_fetch_queue_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, out_ready;
  logic [1:0]    a_count, b_count, a_grant, b_grant;
  logic [DW-1:0] a_data0, a_data1, b_data0, b_data1;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW:0]   level;
  logic          q_reset, q_push0, q_push1, q_pop;
  logic [DW-1:0] q_data0, q_data1;
  logic [DW-1:0] q_data_out = '0;
  logic          q_empty, q_full;

  fetch_queue_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .a_count(a_count), .a_data0(a_data0), .a_data1(a_data1), .a_grant(a_grant),
    .b_count(b_count), .b_data0(b_data0), .b_data1(b_data1), .b_grant(b_grant),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level), .q_reset(q_reset),
    .q_push0(q_push0), .q_data0(q_data0), .q_push1(q_push1), .q_data1(q_data1),
    .q_pop(q_pop), .q_data_out(q_data_out), .q_empty(q_empty), .q_full(q_full)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Queue model: registered read data, cleared by q_reset. Slot activity is
  // captured at the falling edge and applied at the next rising edge.
  logic [DW-1:0] fmem [32];
  logic [4:0]    fwp = '0, frp = '0;
  logic [5:0]    fcnt = '0;
  logic          c_rst = 1'b0, c_p0 = 1'b0, c_p1 = 1'b0, c_pop = 1'b0;
  logic [DW-1:0] c_d0 = '0, c_d1 = '0;

  assign q_empty = (fcnt == 6'd0);
  assign q_full  = (fcnt == 6'd31);

  always @(posedge clk) begin
    if (c_rst) begin
      fwp <= '0; frp <= '0; fcnt <= '0; q_data_out <= '0;
    end else begin
      if (c_pop) q_data_out <= fmem[frp];
      if (c_p0) fmem[fwp] <= c_d0;
      if (c_p1) fmem[fwp + 5'd1] <= c_d1;
      fwp  <= fwp + 5'(c_p0) + 5'(c_p1);
      frp  <= frp + 5'(c_pop);
      fcnt <= fcnt + 6'(c_p0) + 6'(c_p1) - 6'(c_pop);
    end
  end

  // Reference model of the controller; accepted words go to the scoreboard.
  logic [DW-1:0] exp_q[$];
  bit inited = 0;
  int mocc = 0, nocc = 0;
  bit mprio = 0, nprio = 0, mov = 0, nov = 0;

  always @(negedge clk) begin : model
    int ac, bc, lim, ea, eb;
    bit kill, epop;
    c_rst = q_reset; c_p0 = q_push0; c_p1 = q_push1; c_pop = q_pop;
    c_d0 = q_data0; c_d1 = q_data1;
    if (inited) begin
      kill = reset || flush;
      ac = (a_count == 2'd3) ? 2 : int'(a_count);
      bc = (b_count == 2'd3) ? 2 : int'(b_count);
      epop = !kill && (mocc != 0) && (!mov || out_ready);
      lim = epop ? 1 : 2;
      if (31 - mocc < lim) lim = 31 - mocc;
      if (kill) lim = 0;
      ea = 0; eb = 0;
      if (ac != 0 && (bc == 0 || !mprio)) ea = (ac < lim) ? ac : lim;
      else eb = (bc < lim) ? bc : lim;
      chk("m_a_grant", a_grant, ea);
      chk("m_b_grant", b_grant, eb);
      chk("m_q_pop", q_pop, epop);
      chk("m_q_push0", q_push0, (ea + eb) >= 1);
      chk("m_q_push1", q_push1, (ea + eb) == 2);
      chk("m_push1_pop_excl", q_push1 & q_pop, 0);
      chk("m_q_reset", q_reset, kill);
      chk("m_level", level, mocc);
      chk("m_out_valid", out_valid, mov);
      if (ea >= 1) begin chk("m_q_data0", q_data0, a_data0); exp_q.push_back(a_data0); end
      if (ea == 2) begin chk("m_q_data1", q_data1, a_data1); exp_q.push_back(a_data1); end
      if (eb >= 1) begin chk("m_q_data0", q_data0, b_data0); exp_q.push_back(b_data0); end
      if (eb == 2) begin chk("m_q_data1", q_data1, b_data1); exp_q.push_back(b_data1); end
      nocc  = mocc + ea + eb - int'(epop);
      nprio = (ea != 0) ? 1'b1 : (eb != 0) ? 1'b0 : mprio;
      nov   = epop ? 1'b1 : out_ready ? 1'b0 : mov;
      if (kill) begin nocc = 0; nprio = 0; nov = 0; end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      mocc = 0; mprio = 0; mov = 0; inited = 1;
      exp_q.delete();
    end else if (inited) begin
      mocc = nocc; mprio = nprio; mov = nov;
      if (flush) exp_q.delete();
    end
  end

  // Monitor: every consumer handshake must deliver the oldest accepted word.
  always @(negedge clk) begin
    if (inited && !reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_underflow: actual %0h required <none> at t=%0t", out_data, $time);
      end else begin
        chk("sb_order", out_data, exp_q.pop_front());
      end
    end
  end

  // Requesters: each offers consecutive numbered words and advances by its grant.
  int a_seq = 0, b_seq = 0;
  logic [1:0] ga, gb;

  task automatic drive_data();
    a_data0 = 32'hA000_0000 + a_seq; a_data1 = 32'hA000_0000 + a_seq + 1;
    b_data0 = 32'hB000_0000 + b_seq; b_data1 = 32'hB000_0000 + b_seq + 1;
  endtask

  task automatic sample();
    @(negedge clk);
    ga = a_grant; gb = b_grant;
  endtask

  task automatic advance();
    @(posedge clk); #1;
    a_seq += int'(ga); b_seq += int'(gb);
    drive_data();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tot, n, expg;
    logic [DW-1:0] x, ra, rb;
    reset = 1; flush = 0; out_ready = 0; a_count = 2; b_count = 2;
    drive_data();
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst_a_grant", a_grant, 0);
      chk("rst_b_grant", b_grant, 0);
      chk("rst_q_reset", q_reset, 1);
      advance();
    end
    reset = 0; a_count = 0; b_count = 0;
    sample();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_out_data", out_data, 0);
    advance();

    // Fill with no consumer.
    a_count = 2; out_ready = 0; tot = 0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (c == 0 || (c >= 2 && c <= 15)) expg = 2;
      else if (c == 1 || c == 16) expg = 1;
      else expg = 0;
      chk("fill_a_grant", a_grant, expg);
      if (c == 1) begin
        chk("fill_pop", q_pop, 1);
        chk("fill_push1", q_push1, 0);
      end
      if (c >= 2) chk("fill_hold", out_data, 32'hA000_0000);
      tot += int'(ga);
      advance();
    end

    // Near full, then one accept at a time frees one slot.
    a_count = 0; b_count = 2; out_ready = 0;
    sample(); chk("fill_level", level, 31); chk("fill_total", tot, 32);
    chk("nf_full_grant", b_grant, 0); advance();
    out_ready = 1;
    sample(); chk("nf_pop_grant", b_grant, 0); chk("nf_pop", q_pop, 1); advance();
    out_ready = 0;
    sample(); chk("nf_level30", level, 30); chk("nf_grant1", b_grant, 1);
    chk("nf_push1", q_push1, 0); advance();
    sample(); chk("nf_level31", level, 31); chk("nf_grant0", b_grant, 0); advance();
    out_ready = 1;
    sample(); chk("nf_accept_grant", b_grant, 0); advance();
    out_ready = 0;
    sample(); chk("nf_regrant", b_grant, 1); advance();

    // Drain to ten words, then flush mid-stream while the consumer accepts.
    b_count = 0; out_ready = 1; n = 0;
    while (level != 10 && n < 60) begin sample(); advance(); n++; end
    chk("drain_to_10", level, 10);
    flush = 1; a_count = 1;
    sample(); chk("fl_out_valid", out_valid, 1); chk("fl_a_grant", a_grant, 0);
    chk("fl_q_reset", q_reset, 1); chk("fl_pop", q_pop, 0); advance();
    flush = 0; out_ready = 0;
    sample(); chk("fl_next_valid", out_valid, 0); chk("fl_next_level", level, 0);
    chk("fl_push_x", a_grant, 1); x = a_data0; advance();
    a_count = 0; out_ready = 1;
    sample(); chk("fl_x_pop", q_pop, 1); chk("fl_x_notyet", out_valid, 0); advance();
    sample(); chk("fl_x_valid", out_valid, 1); chk("fl_x_data", out_data, x); advance();

    // Round-robin from a freshly flushed state.
    flush = 1; sample(); advance(); flush = 0;
    a_count = 1; b_count = 1; out_ready = 1;
    ra = 32'hA000_0000 + a_seq; rb = 32'hB000_0000 + b_seq;
    for (int c = 0; c < 12; c++) begin
      sample();
      chk("rr_a_grant", a_grant, (c % 2 == 0) ? 1 : 0);
      chk("rr_b_grant", b_grant, (c % 2 == 0) ? 0 : 1);
      if (c == 2) chk("rr_first_a", out_data, ra);
      if (c == 3) chk("rr_first_b", out_data, rb);
      advance();
    end

    // Random counts and backpressure.
    for (int i = 0; i < 1000; i++) begin
      a_count = 2'($urandom_range(0, 3));
      b_count = 2'($urandom_range(0, 3));
      out_ready = 1'($urandom_range(0, 1));
      sample(); advance();
    end

    a_count = 0; b_count = 0; out_ready = 1;
    for (int i = 0; i < 40; i++) begin sample(); advance(); end
    chk("end_level", level, 0);
    chk("end_scoreboard", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_queue_ctrl.md
# fetch_queue_ctrl

Controller and two-requester arbiter for the dual-push instruction queue (a `fifo` instance: two push slots per cycle, one pop, registered read data). It shares the queue's push slots between requester A (fetch) and requester B (replay) using round-robin arbitration. It keeps an exact occupancy count, sequences pops into a valid/ready consumer interface, and performs pipeline flush by resetting the queue.

## Interface

- `DATA_WIDTH`, 32, width of one queue word.
- `ADDR_WIDTH`, 5, queue address width; must match the attached queue.
- `CAPACITY`, `(1<<ADDR_WIDTH)-1` (31), maximum words stored in the queue.

Ports:

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous, active-high; discards all queued and presented words.
- `a_count` in 2: number of words A offers this cycle (0, 1 or 2; 3 is treated as 2).
- `a_data0`, `a_data1` in DATA_WIDTH: A's words, in order.
- `a_grant` out 2: words accepted from A this cycle (combinational).
- `b_count`, `b_data0`, `b_data1`, `b_grant`: same as the A ports, for requester B.
- `out_valid` out 1: `out_data` holds a valid word (registered).
- `out_data` out DATA_WIDTH: wired directly to `q_data_out`.
- `out_ready` in 1: consumer accepts `out_data` this cycle.
- `level` out ADDR_WIDTH+1: current queue occupancy (registered).
- `q_reset` out 1: `reset | flush`.
- `q_push0`, `q_data0`, `q_push1`, `q_data1` out: queue push slots.
- `q_pop` out 1: queue pop.
- `q_data_out` in DATA_WIDTH: queue registered read data.
- `q_empty`, `q_full` in 1: status inputs; used only by assertions, not for control.

## Operation

- State: `occ` (ADDR_WIDTH+1 bits), `prio` (0 = A first), `out_valid`. `level = occ`.
- Pop rule: `q_pop = (occ != 0) && (!out_valid || out_ready) && !flush && !reset`.
- Slot limit: `free = CAPACITY - occ`. `allowed = q_pop ? min(1, free) : min(2, free)`. A cycle that pops never uses `q_push1`.
- Arbitration: only one requester is granted per cycle; words from A and B are never mixed.
  - If both counts are nonzero, the `prio` holder wins.
  - If only one count is nonzero, that requester wins.
  - Winner grant = `min(count, allowed)`. The loser's grant is 0.
  - Pops do not free space for pushes in the same cycle.
- Push mapping:
  - `q_push0 = grant >= 1`, `q_data0 = winner data0`.
  - `q_push1 = grant == 2`, `q_data1 = winner data1`.
- Partial grant: on grant 1 of 2, only data0 is consumed. The requester re-presents data1 as data0 in a later cycle.
- `prio` update: after a nonzero grant, `prio` points to the other requester. It is unchanged when the grant is 0.
- `occ <= occ + grant - q_pop`. This never underflows and never exceeds CAPACITY.
- `out_valid` update:
  - `q_pop` → 1.
  - Otherwise, `out_ready` → 0.
  - Otherwise, hold.
- `out_data` stays stable while `out_valid && !out_ready`, because the queue only updates read data on a pop.
- Flush or reset cycle: grants are 0, `q_pop` is 0 and `q_reset` is 1. Next state: `occ = 0`, `out_valid = 0`, `prio = A`.
- Reset values: `out_valid` 0, `level` 0, `a_grant`/`b_grant` 0, `q_push*` 0, `q_pop` 0, `out_data` 0 (the queue clears its read data).

## Timing

- Grants are combinational on the same cycle. A requester treats its words as consumed at the clock edge.
- Pop in cycle t → `out_valid` = 1 and data on `out_data` in t+1.
- Word pushed in cycle t → earliest pop in t+1 → earliest `out_valid` in t+2.
- Steady-state throughput is one word per cycle out. Input is two words per cycle when no pop occurs, otherwise one.
- Flush asserted in cycle t: `out_valid` = 0 and `level` = 0 in t+1. Pushes are accepted again from t+1.
- Flush in the same cycle as `out_ready`: the consumer's acceptance stands; nothing else pops.

## Test plan

- **Reset:** hold `reset` for 2 cycles with both counts = 2. Required: grants 0 and `q_reset` 1 during reset; afterwards `out_valid` 0, `level` 0, `out_data` 0.
- **Fill:** A count = 2 every cycle, `out_ready` = 0, words numbered 0..N. Required:
  - cycle 0 grant 2; cycle 1 grant 1 with `q_pop` and `q_push1` 0; grant 2 per cycle after that.
  - `level` saturates at 31 and `a_grant` drops to 0.
  - Total 32 words accepted; `out_data` = word 0 and holds.
- **Round-robin:** A and B both count = 1 continuously, `out_ready` = 1. Required: grants alternate A,B,A,B starting with A; `out_data` shows A0,B0,A1,B1,...
- **Near full:** `occ` = 30, no pop, B count = 2. Required: `b_grant` 1, then `b_grant` 0 at `level` 31. After one consumer accept, `b_grant` 1 again.
- **Flush mid-stream:** `level` = 10, `out_valid` = 1, assert `flush` 1 cycle. Required: zero grants and `q_reset` 1 in the flush cycle; next cycle `out_valid` 0 and `level` 0. A word X pushed the cycle after flush appears with `out_valid` 2 cycles later as `out_data` = X.
- **Backpressure:** toggle `out_ready` pseudo-randomly over 1000 cycles with random counts. Required: output order equals acceptance order, no loss or duplication, `level` always matches the scoreboard, and `q_push1 & q_pop` is never 1.
